// File: rtl/axisadd_lite_arbiter.sv
// Two-requester round-robin arbiter driving one AXI4-Lite master port.
// Each accepted command becomes exactly one AXI4-Lite read or write transaction.
module axisadd_lite_arbiter #(
  parameter int unsigned C_ADDR_WIDTH = 4,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0]                  req_write,
  input  logic [2*C_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                  rsp_valid,
  output logic [C_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        busy,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);

  localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_MASK = ~C_ADDR_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_e;

  state_e                    state_q;
  logic                      last_grant_q;
  logic                      owner_q;
  logic [1:0]                req_ready_q;
  logic [C_ADDR_WIDTH-1:0]   addr_q;
  logic [C_DATA_WIDTH-1:0]   wdata_q;
  logic                      awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [1:0]                rsp_valid_q;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]                rsp_resp_q;
  logic                      busy_q;

  logic                      win_c;
  logic                      sel_write_c;
  logic [C_ADDR_WIDTH-1:0]   sel_addr_c;
  logic [C_DATA_WIDTH-1:0]   sel_wdata_c;
  logic [1:0]                owner_onehot_c;

  // Contention goes to whoever was not granted last; a lone request simply wins.
  always_comb begin
    win_c = req_valid[1];
    if (req_valid == 2'b11) win_c = ~last_grant_q;
  end

  assign sel_write_c    = owner_q ? req_write[1] : req_write[0];
  assign sel_addr_c     = owner_q ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH]
                                  : req_addr[C_ADDR_WIDTH-1:0];
  assign sel_wdata_c    = owner_q ? req_wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH]
                                  : req_wdata[C_DATA_WIDTH-1:0];
  assign owner_onehot_c = owner_q ? 2'b10 : 2'b01;

  // IDLE spends one cycle registering req_ready; the command is taken on the ready cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      req_ready_q  <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_ready_q != 2'b00) begin
            req_ready_q  <= 2'b00;
            last_grant_q <= owner_q;
            addr_q       <= sel_addr_c & ADDR_MASK;
            wdata_q      <= sel_wdata_c;
            busy_q       <= 1'b1;
            if (sel_write_c) begin
              state_q   <= S_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end else if (req_valid != 2'b00) begin
            owner_q     <= win_c;
            req_ready_q <= win_c ? 2'b10 : 2'b01;
          end
        end
        S_WR: begin
          // AW and W complete independently; move on once both have handshaken.
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            state_q  <= S_WR_RESP;
            bready_q <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= owner_onehot_c;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= M_AXI_BRESP;
            state_q     <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= owner_onehot_c;
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_resp_q  <= M_AXI_RRESP;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = busy_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = {STRB_W{1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
